// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types and elaboration helpers for the I2S transmit path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2s_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } i2s_tx_state_t;

  // Philips framing: data MSB trails the word-select edge by one bit clock.
  localparam int PHILIPS_DELAY = 1;

  function automatic int half_div(input int clk_freq, input int i2s_clk_freq);
    int d;
    d = clk_freq / (2 * i2s_clk_freq);
    if (d < 1) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// i2s_bclk_gen: bit-clock divider, toggles i2s_clk every HALF_DIV system clocks.
// Latency: first rising edge HALF_DIV cycles after en goes high; fall strobe is same-cycle.
// Backpressure: none; en=0 clears the divider and holds i2s_clk low.
module i2s_bclk_gen #(
  parameter int HALF_DIV = 33
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic i2s_clk,
  output logic fall
);

  localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(HALF_DIV - 1);

  logic [CW-1:0] div_cnt;
  logic          tc;

  assign tc   = en && (div_cnt == TERM);
  // Strobe marks the cycle whose closing edge drives i2s_clk 1 -> 0.
  assign fall = tc && i2s_clk;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      div_cnt <= '0;
      i2s_clk <= 1'b0;
    end else if (tc) begin
      div_cnt <= '0;
      i2s_clk <= ~i2s_clk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: I2S Philips master transmitter, one mono sample sent on both slots. Option: I2S_TX_HOLD_ON_UNDERRUN_EN.
// Latency: accepted sample goes out at the next frame load; ws/sd follow each i2s_clk fall by 1 clk.
// Backpressure: pcm_ready low while the one-entry buffer holds a sample.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int CLK_FREQ            = 100_000_000,
  parameter int I2S_CLK_FREQ        = 1_500_000,
  parameter int DATA_IN_SIZE        = 16,
  parameter int SLOT_SIZE           = 32,
  parameter int SIZE_UNDERRUN_COUNT = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic [DATA_IN_SIZE-1:0]        pcm_in,
  input  logic                           pcm_valid,
  output logic                           pcm_ready,
  output logic                           i2s_clk,
  output logic                           i2s_ws,
  output logic                           i2s_sd,
  output logic                           frame_start,
  output logic                           underrun,
  output logic [SIZE_UNDERRUN_COUNT-1:0] underrun_count
);

  localparam int HALF_DIV   = half_div(CLK_FREQ, I2S_CLK_FREQ);
  localparam int FRAME_BITS = 2 * SLOT_SIZE;
  localparam int BW         = $clog2(FRAME_BITS);
  localparam int PAD        = SLOT_SIZE - DATA_IN_SIZE;

  localparam logic [BW-1:0] SLOT_CNT = BW'(SLOT_SIZE);
  localparam logic [BW-1:0] LAST_CNT = BW'(FRAME_BITS - 1);

  i2s_tx_state_t state_q, state_d;

  logic                    load;
  logic                    bclk_en;
  logic                    bclk_fall;
  logic                    accept;
  logic                    buf_full_q;
  logic [DATA_IN_SIZE-1:0] buf_q;
  logic [DATA_IN_SIZE-1:0] underrun_sample;
  logic [DATA_IN_SIZE-1:0] load_sample;
  logic [SLOT_SIZE-1:0]    slot_img;
  logic [FRAME_BITS-1:0]   frame_img;
  logic [FRAME_BITS-1:0]   shift_q;
  logic [BW-1:0]           bit_cnt_q;

  assign bclk_en   = (state_q == RUN) && enable;
  assign accept    = pcm_valid && !buf_full_q;
  assign pcm_ready = !buf_full_q;

  i2s_bclk_gen #(
    .HALF_DIV (HALF_DIV)
  ) u_bclk_gen (
    .clk     (clk),
    .rst     (rst),
    .en      (bclk_en),
    .i2s_clk (i2s_clk),
    .fall    (bclk_fall)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (bclk_fall && (bit_cnt_q == LAST_CNT)) begin
          load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
  logic [DATA_IN_SIZE-1:0] last_q;

  assign underrun_sample = last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= '0;
    end else if (load && buf_full_q) begin
      last_q <= buf_q;
    end
  end
`else
  assign underrun_sample = '0;
`endif

  // Left and right carry the same slot; the whole frame is pre-shifted by the Philips delay.
  assign load_sample = buf_full_q ? buf_q : underrun_sample;
  assign slot_img    = SLOT_SIZE'(load_sample) << PAD;
  assign frame_img   = {slot_img, slot_img} >> PHILIPS_DELAY;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      buf_full_q     <= 1'b0;
      buf_q          <= '0;
      frame_start    <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= '0;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      i2s_ws         <= 1'b0;
      i2s_sd         <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_start <= load;
      underrun    <= load && !buf_full_q;

      if (load && !buf_full_q && (underrun_count != '1)) begin
        underrun_count <= underrun_count + 1'b1;
      end

      // A sample accepted alongside a load lands after that load and waits for the next frame.
      if (load && buf_full_q) begin
        buf_full_q <= 1'b0;
      end else if (accept) begin
        buf_full_q <= 1'b1;
        buf_q      <= pcm_in;
      end

      if (state_d == IDLE) begin
        shift_q   <= '0;
        bit_cnt_q <= '0;
        i2s_ws    <= 1'b0;
        i2s_sd    <= 1'b0;
      end else begin
        i2s_ws <= (bit_cnt_q >= SLOT_CNT);
        i2s_sd <= shift_q[FRAME_BITS-1];
        if (load) begin
          shift_q   <= frame_img;
          bit_cnt_q <= '0;
        end else if (bclk_fall) begin
          shift_q   <= shift_q << 1;
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
      end
    end
  end

endmodule
